// File: rtl/fifo_pkt_writer_if.sv
// Handshake and bus bundle between a frame requester / byte source / write FIFO
// and the fifo_pkt_writer framing engine.
interface fifo_pkt_writer_if #(
  parameter int LEN_W = 12
);
  logic             err;
  logic             fs;
  logic             fd;
  logic [LEN_W-1:0] data_len;
  logic [15:0]      part;
  logic             pat_mode;
  logic [7:0]       src_data;
  logic             src_valid;
  logic             src_ready;
  logic             fifo_full;
  logic [7:0]       fifo_txd;
  logic             fifo_txen;
  logic             aborted;
  logic [7:0]       so;

  // Writer side: consumes requests, stream bytes and FIFO status; drives the FIFO.
  modport slave (
    input  err, fs, data_len, part, pat_mode, src_data, src_valid, fifo_full,
    output fd, src_ready, fifo_txd, fifo_txen, aborted, so
  );

  // Requester / source / FIFO side.
  modport master (
    output err, fs, data_len, part, pat_mode, src_data, src_valid, fifo_full,
    input  fd, src_ready, fifo_txd, fifo_txen, aborted, so
  );
endinterface

// File: rtl/fifo_pkt_writer.sv
// Frames a payload (4-byte header, payload, optional checksum) and writes it
// byte-by-byte into a downstream FIFO, stalling on fifo_full and aborting on err.
module fifo_pkt_writer #(
  parameter int         LEN_W    = 12,
  parameter logic [7:0] SYNC_HI  = 8'h55,
  parameter logic [7:0] SYNC_LO  = 8'hAA,
  parameter bit         CKSUM_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  fifo_pkt_writer_if.slave bus
);

  typedef enum logic [7:0] {
    S_IDLE = 8'h01,
    S_PREP = 8'h02,
    S_HEAD = 8'h04,
    S_WORK = 8'h08,
    S_TAIL = 8'h10,
    S_LAST = 8'h20,
    S_ABRT = 8'h40
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      part_q, part_d;
  logic             pat_q, pat_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic             aborted_q, aborted_d;

  logic [7:0]       head_byte;
  logic [7:0]       cur_byte;
  logic             offer;
  logic             wr_en;
  logic             src_ready_c;
  logic             fd_c;
  logic             last_head;
  logic             last_payload;
  logic             in_frame;

  assign last_head    = (idx_q == 2'd3);
  assign last_payload = (cnt_q == (len_q - LEN_W'(1)));
  assign in_frame     = (state_q == S_PREP) || (state_q == S_HEAD) ||
                        (state_q == S_WORK) || (state_q == S_TAIL);

  always_comb begin
    head_byte = SYNC_HI;
    case (idx_q)
      2'd0:    head_byte = SYNC_HI;
      2'd1:    head_byte = SYNC_LO;
      2'd2:    head_byte = part_q[15:8];
      default: head_byte = part_q[7:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; err in an active state wins over any write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fs) state_d = S_PREP;
      end
      S_PREP: begin
        if (bus.err)             state_d = S_ABRT;
        else if (!bus.fifo_full) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (bus.err) begin
          state_d = S_ABRT;
        end else if (wr_en && last_head) begin
          if (len_q != '0)   state_d = S_WORK;
          else if (CKSUM_EN) state_d = S_TAIL;
          else               state_d = S_LAST;
        end
      end
      S_WORK: begin
        if (bus.err) begin
          state_d = S_ABRT;
        end else if (wr_en && last_payload) begin
          state_d = CKSUM_EN ? S_TAIL : S_LAST;
        end
      end
      S_TAIL: begin
        if (bus.err)    state_d = S_ABRT;
        else if (wr_en) state_d = S_LAST;
      end
      S_LAST: begin
        if (!bus.fs) state_d = S_IDLE;
      end
      S_ABRT: begin
        if (!bus.fs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the byte on offer and its write strobe are combinational.
  always_comb begin
    cur_byte    = 8'h00;
    offer       = 1'b0;
    src_ready_c = 1'b0;
    fd_c        = 1'b0;
    case (state_q)
      S_HEAD: begin
        cur_byte = head_byte;
        offer    = !bus.fifo_full;
      end
      S_WORK: begin
        if (pat_q) begin
          cur_byte = 8'(cnt_q) + 8'd4;
          offer    = !bus.fifo_full;
        end else begin
          cur_byte    = bus.src_data;
          offer       = bus.src_valid && !bus.fifo_full;
          src_ready_c = !bus.fifo_full && !bus.err;
        end
      end
      S_TAIL: begin
        cur_byte = ~sum_q + 8'd1;
        offer    = !bus.fifo_full;
      end
      S_LAST: begin
        fd_c = 1'b1;
      end
      default: begin
        cur_byte = 8'h00;
      end
    endcase
    wr_en = offer && in_frame && !bus.err;
  end

  // Frame context and running counters.
  always_comb begin
    len_d     = len_q;
    part_d    = part_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    aborted_d = (state_d == S_ABRT) && (state_q != S_ABRT);
    case (state_q)
      S_IDLE: begin
        if (bus.fs) begin
          len_d  = bus.data_len;
          part_d = bus.part;
          pat_d  = bus.pat_mode;
          idx_d  = 2'd0;
          cnt_d  = '0;
          sum_d  = 8'h00;
        end
      end
      S_HEAD: begin
        if (wr_en) begin
          idx_d = idx_q + 2'd1;
          sum_d = sum_q + cur_byte;
        end
      end
      S_WORK: begin
        if (wr_en) begin
          cnt_d = cnt_q + LEN_W'(1);
          sum_d = sum_q + cur_byte;
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      part_q    <= 16'h0000;
      pat_q     <= 1'b0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      sum_q     <= 8'h00;
      aborted_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      part_q    <= part_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.fifo_txen = wr_en;
  assign bus.fifo_txd  = wr_en ? cur_byte : 8'h00;
  assign bus.src_ready = src_ready_c;
  assign bus.fd        = fd_c;
  assign bus.aborted   = aborted_q;
  assign bus.so        = state_q;

endmodule
